// File: rtl/compy_bus_arbiter.sv
// compy_bus_arbiter: shares one synchronous-read memory port between the chroni video
// fetch path and the CPU requester. Chroni has priority, but the CPU always gets a slot.
module compy_bus_arbiter #(
  parameter int unsigned RD_LATENCY       = 1,
  parameter int unsigned CHRONI_MAX_BURST = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        chroni_rd_req,
  input  logic [13:0] chroni_addr,
  input  logic [7:0]  chroni_page,
  output logic        chroni_rd_ack,
  output logic [7:0]  chroni_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [16:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;
  typedef enum logic {OWN_CHRONI, OWN_CPU} owner_t;

  localparam logic [2:0] LAT_LOAD  = 3'(RD_LATENCY);
  localparam logic [3:0] BURST_MAX = 4'(CHRONI_MAX_BURST);

  state_t      state;
  state_t      state_nxt;
  owner_t      owner;
  logic        acc_we;
  logic [2:0]  lat_cnt;
  logic [3:0]  streak;
  logic        grant_chroni;
  logic        grant_cpu;
  logic [16:0] chroni_full_addr;

  // Page is in 512-byte units; the sum wraps silently at the 17-bit boundary.
  assign chroni_full_addr = {chroni_page, 9'b0} + {3'b0, chroni_addr};

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant_chroni = 1'b0;
    grant_cpu    = 1'b0;
    if (state == ST_IDLE) begin
      if (cpu_req && (!chroni_rd_req || streak >= BURST_MAX)) begin
        grant_cpu = 1'b1;
      end else if (chroni_rd_req) begin
        grant_chroni = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order between always_ff blocks.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    chroni_rd_ack = 1'b0;
    cpu_ack       = 1'b0;
    busy          = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (grant_chroni || grant_cpu) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_rd    = !acc_we;
        mem_wr    = acc_we;
        state_nxt = acc_we ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == 3'd1) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        chroni_rd_ack = (owner == OWN_CHRONI);
        cpu_ack       = (owner == OWN_CPU);
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Access fields are latched at grant, so requester inputs are don't-care afterwards.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      owner       <= OWN_CHRONI;
      acc_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lat_cnt     <= '0;
      streak      <= '0;
      chroni_data <= '0;
      cpu_rdata   <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (grant_cpu || !cpu_req) begin
          streak <= '0;
        end else if (grant_chroni && streak != 4'hF) begin
          streak <= streak + 4'd1;
        end
      end

      if (grant_chroni) begin
        owner    <= OWN_CHRONI;
        acc_we   <= 1'b0;
        mem_addr <= chroni_full_addr;
      end else if (grant_cpu) begin
        owner     <= OWN_CPU;
        acc_we    <= cpu_we;
        mem_addr  <= {1'b0, cpu_addr};
        mem_wdata <= cpu_wdata;
      end

      if (state == ST_ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          if (owner == OWN_CHRONI) chroni_data <= mem_rdata;
          else                     cpu_rdata   <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_compy_bus_arbiter.sv
// Self-checking bench for compy_bus_arbiter: two instances (RD_LATENCY 1 and 3) on a
// behavioural memory, ack data checked against a scoreboard of expected bytes.
module tb_compy_bus_arbiter;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        reset;
  logic        chroni_rd_req, chroni_rd_ack;
  logic [13:0] chroni_addr;
  logic [7:0]  chroni_page, chroni_data;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [16:0] mem_addr;
  logic        mem_rd, mem_wr, busy;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        chroni_rd_req_3, chroni_rd_ack_3;
  logic [13:0] chroni_addr_3;
  logic [7:0]  chroni_page_3, chroni_data_3;
  logic        cpu_req_3, cpu_we_3, cpu_ack_3;
  logic [15:0] cpu_addr_3;
  logic [7:0]  cpu_wdata_3, cpu_rdata_3;
  logic [16:0] mem_addr_3;
  logic        mem_rd_3, mem_wr_3, busy_3;
  logic [7:0]  mem_wdata_3, mem_rdata_3;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic we; logic [7:0] data; } cpu_exp_t;
  logic [7:0] sb_chroni[$];
  logic [7:0] sb_chroni_3[$];
  cpu_exp_t   sb_cpu[$];

  compy_bus_arbiter #(.RD_LATENCY(1), .CHRONI_MAX_BURST(4)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .chroni_rd_req(chroni_rd_req), .chroni_addr(chroni_addr), .chroni_page(chroni_page),
    .chroni_rd_ack(chroni_rd_ack), .chroni_data(chroni_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  compy_bus_arbiter #(.RD_LATENCY(3), .CHRONI_MAX_BURST(4)) dut3 (
    .sys_clk(sys_clk), .reset(reset),
    .chroni_rd_req(chroni_rd_req_3), .chroni_addr(chroni_addr_3), .chroni_page(chroni_page_3),
    .chroni_rd_ack(chroni_rd_ack_3), .chroni_data(chroni_data_3),
    .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
    .cpu_ack(cpu_ack_3), .cpu_rdata(cpu_rdata_3),
    .mem_addr(mem_addr_3), .mem_rd(mem_rd_3), .mem_wr(mem_wr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  // Behavioural memory: fixed pattern plus a few planted bytes and the last write.
  logic        wr_valid_q;
  logic [16:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [7:0]  rd_pipe_1;
  logic [7:0]  rd_pipe_3 [0:2];

  function logic [7:0] mem_val(input logic [16:0] a);
    if (wr_valid_q && a == wr_addr_q) return wr_data_q;
    case (a)
      17'h00205: return 8'hA5;
      17'h00300: return 8'h11;
      17'h00400: return 8'h22;
      default:   return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h5A;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    if (reset) wr_valid_q <= 1'b0;
    else if (mem_wr) begin
      wr_valid_q <= 1'b1;
      wr_addr_q  <= mem_addr;
      wr_data_q  <= mem_wdata;
    end
    rd_pipe_1    <= mem_rd ? mem_val(mem_addr) : 8'hEE;
    rd_pipe_3[0] <= mem_rd_3 ? mem_val(mem_addr_3) : 8'hEE;
    rd_pipe_3[1] <= rd_pipe_3[0];
    rd_pipe_3[2] <= rd_pipe_3[1];
  end
  assign mem_rdata   = rd_pipe_1;
  assign mem_rdata_3 = rd_pipe_3[2];

  // Scoreboard: every ack pops one expected entry and checks its data.
  cpu_exp_t   mon_cpu;
  logic [7:0] mon_byte;
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (mem_rd && mem_wr) begin
        miscompares++;
        $display("FAIL strobe_overlap: mem_rd=%b mem_wr=%b, required not both high", mem_rd, mem_wr);
      end
      if (chroni_rd_ack) begin
        vectors++;
        if (sb_chroni.size() == 0) begin
          miscompares++;
          $display("FAIL chroni_ack_unexpected: ack with no pending chroni read");
        end else begin
          mon_byte = sb_chroni.pop_front();
          if (chroni_data !== mon_byte) begin
            miscompares++;
            $display("FAIL chroni_data: got %h, required %h", chroni_data, mon_byte);
          end
        end
      end
      if (chroni_rd_ack_3) begin
        vectors++;
        if (sb_chroni_3.size() == 0) begin
          miscompares++;
          $display("FAIL chroni3_ack_unexpected: ack with no pending chroni read");
        end else begin
          mon_byte = sb_chroni_3.pop_front();
          if (chroni_data_3 !== mon_byte) begin
            miscompares++;
            $display("FAIL chroni3_data: got %h, required %h", chroni_data_3, mon_byte);
          end
        end
      end
      if (cpu_ack) begin
        vectors++;
        if (sb_cpu.size() == 0) begin
          miscompares++;
          $display("FAIL cpu_ack_unexpected: ack with no pending CPU access");
        end else begin
          mon_cpu = sb_cpu.pop_front();
          if (!mon_cpu.we && cpu_rdata !== mon_cpu.data) begin
            miscompares++;
            $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, mon_cpu.data);
          end
        end
      end
    end
  end

  task automatic chroni_op(input logic [7:0] page, input logic [13:0] off,
                           input logic [7:0] exp_data, output int lat, output logic [16:0] seen);
    chroni_page = page; chroni_addr = off; chroni_rd_req = 1'b1;
    sb_chroni.push_back(exp_data);
    lat = 0; seen = '0;
    do begin
      @(negedge sys_clk); lat++;
      if (mem_rd) seen = mem_addr;
    end while (!chroni_rd_ack && lat < 50);
    if (!chroni_rd_ack) begin
      vectors++; miscompares++;
      $display("FAIL chroni_timeout: no ack after %0d cycles", lat);
    end
    chroni_rd_req = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    chroni_rd_req = 0; chroni_addr = '0; chroni_page = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    chroni_rd_req_3 = 0; chroni_addr_3 = '0; chroni_page_3 = '0;
    cpu_req_3 = 0; cpu_we_3 = 0; cpu_addr_3 = '0; cpu_wdata_3 = '0;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if ({chroni_rd_ack, cpu_ack, mem_rd, mem_wr, busy, chroni_data, cpu_rdata, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0",
               {chroni_rd_ack, cpu_ack, mem_rd, mem_wr, busy, chroni_data, cpu_rdata, mem_addr, mem_wdata});
    end
    vectors++;
    if ({busy_3, chroni_data_3, mem_addr_3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_3: got %h, required 0", {busy_3, chroni_data_3, mem_addr_3});
    end
    reset = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_read();
    chroni_page = 8'h01; chroni_addr = 14'h0005; chroni_rd_req = 1'b1;
    sb_chroni.push_back(8'hA5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      vectors++;
      if (mem_rd !== (k == 1) || mem_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL single_strobe c%0d: mem_rd=%b mem_wr=%b, required %b/0", k, mem_rd, mem_wr, k == 1);
      end
      vectors++;
      if (busy !== (k <= 3)) begin
        miscompares++;
        $display("FAIL single_busy c%0d: got %b, required %b", k, busy, k <= 3);
      end
      vectors++;
      if (chroni_rd_ack !== (k == 3)) begin
        miscompares++;
        $display("FAIL single_ack c%0d: got %b, required %b", k, chroni_rd_ack, k == 3);
      end
      if (k == 1) begin
        vectors++;
        if (mem_addr !== 17'h00205) begin
          miscompares++;
          $display("FAIL single_addr: got %h, required 00205", mem_addr);
        end
      end
      if (k == 3) chroni_rd_req = 1'b0;
    end
  endtask

  task automatic test_cpu_write();
    cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    sb_cpu.push_back('{we: 1'b1, data: 8'h00});
    for (int k = 1; k <= 3; k++) begin
      @(negedge sys_clk);
      vectors++;
      if (mem_wr !== (k == 1) || mem_rd !== 1'b0) begin
        miscompares++;
        $display("FAIL write_strobe c%0d: mem_wr=%b mem_rd=%b, required %b/0", k, mem_wr, mem_rd, k == 1);
      end
      vectors++;
      if (cpu_ack !== (k == 2)) begin
        miscompares++;
        $display("FAIL write_ack c%0d: got %b, required %b", k, cpu_ack, k == 2);
      end
      if (k == 1) begin
        vectors++;
        if (mem_addr !== 17'h01234 || mem_wdata !== 8'h3C) begin
          miscompares++;
          $display("FAIL write_fields: addr %h data %h, required 01234 3c", mem_addr, mem_wdata);
        end
      end
      if (k == 2) cpu_req = 1'b0;
    end
    // Read the byte back; read latency is RD_LATENCY+2 = 3.
    begin
      int lat = 0;
      cpu_we = 1'b0; cpu_req = 1'b1;
      sb_cpu.push_back('{we: 1'b0, data: 8'h3C});
      do begin @(negedge sys_clk); lat++; end while (!cpu_ack && lat < 50);
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL cpu_read_latency: got %0d, required 3", lat);
      end
      cpu_req = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_starvation();
    int n = 0, cyc = 0, last = 0;
    chroni_page = 8'h02; chroni_addr = 14'h0010;
    cpu_we = 1'b0; cpu_addr = 16'h0400;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) sb_cpu.push_back('{we: 1'b0, data: 8'h22});
      else                  sb_chroni.push_back(mem_val(17'h00410));
    end
    chroni_rd_req = 1'b1; cpu_req = 1'b1;
    while (n < 10 && cyc < 200) begin
      @(negedge sys_clk); cyc++;
      if (chroni_rd_ack || cpu_ack) begin
        vectors++;
        if (cpu_ack !== (n == 4 || n == 9) || chroni_rd_ack === cpu_ack) begin
          miscompares++;
          $display("FAIL grant_order #%0d: chroni_ack=%b cpu_ack=%b, required cpu=%b", n, chroni_rd_ack, cpu_ack, n == 4 || n == 9);
        end
        if (n > 0) begin
          vectors++;
          if (cyc - last !== 4) begin
            miscompares++;
            $display("FAIL ack_spacing #%0d: got %0d cycles, required 4", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n == 10) begin chroni_rd_req = 1'b0; cpu_req = 1'b0; end
      end
    end
    if (n < 10) begin
      vectors++; miscompares++;
      $display("FAIL starvation_timeout: %0d of 10 acks seen", n);
      chroni_rd_req = 1'b0; cpu_req = 1'b0;
    end
    @(negedge sys_clk);
  endtask

  task automatic test_wrap_latency();
    int lat1 = 0, lat3 = 0, cyc = 0;
    logic [16:0] seen1 = '0, seen3 = '0;
    chroni_page = 8'hFF; chroni_addr = 14'h3FFF; chroni_rd_req = 1'b1;
    chroni_page_3 = 8'hFF; chroni_addr_3 = 14'h3FFF; chroni_rd_req_3 = 1'b1;
    sb_chroni.push_back(mem_val(17'h03DFF));
    sb_chroni_3.push_back(mem_val(17'h03DFF));
    while ((lat1 == 0 || lat3 == 0) && cyc < 50) begin
      @(negedge sys_clk); cyc++;
      if (mem_rd) seen1 = mem_addr;
      if (mem_rd_3) seen3 = mem_addr_3;
      if (chroni_rd_ack) begin lat1 = cyc; chroni_rd_req = 1'b0; end
      if (chroni_rd_ack_3) begin lat3 = cyc; chroni_rd_req_3 = 1'b0; end
    end
    chroni_rd_req = 1'b0; chroni_rd_req_3 = 1'b0;
    vectors++;
    if (seen1 !== 17'h03DFF || seen3 !== 17'h03DFF) begin
      miscompares++;
      $display("FAIL wrap_addr: got %h/%h, required 03dff", seen1, seen3);
    end
    vectors++;
    if (lat1 !== 3) begin
      miscompares++;
      $display("FAIL latency_1: ack at cycle %0d, required 3", lat1);
    end
    vectors++;
    if (lat3 !== 5) begin
      miscompares++;
      $display("FAIL latency_3: ack at cycle %0d, required 5", lat3);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_isolation();
    int lat;
    logic [16:0] seen;
    logic [7:0] cpu_before;
    cpu_before = cpu_rdata;
    chroni_op(8'h01, 14'h0100, 8'h11, lat, seen);
    vectors++;
    if (cpu_rdata !== cpu_before) begin
      miscompares++;
      $display("FAIL cpu_rdata_isolation: got %h, required %h", cpu_rdata, cpu_before);
    end
    cpu_we = 1'b0; cpu_addr = 16'h0400; cpu_req = 1'b1;
    sb_cpu.push_back('{we: 1'b0, data: 8'h22});
    lat = 0;
    do begin
      @(negedge sys_clk); lat++;
      vectors++;
      if (chroni_data !== 8'h11) begin
        miscompares++;
        $display("FAIL chroni_data_isolation c%0d: got %h, required 11", lat, chroni_data);
      end
    end while (!cpu_ack && lat < 50);
    vectors++;
    if (cpu_rdata !== 8'h22) begin
      miscompares++;
      $display("FAIL isolation_cpu_rdata: got %h, required 22", cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    logic [16:0] seen;
    chroni_page = 8'h01; chroni_addr = 14'h0005; chroni_rd_req = 1'b1;
    repeat (2) @(negedge sys_clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_wait_busy: got %b, required 1", busy);
    end
    reset = 1'b1; chroni_rd_req = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if ({chroni_rd_ack, cpu_ack, mem_rd, mem_wr, busy, chroni_data, cpu_rdata, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL mid_wait_reset_outputs: got %h, required 0",
               {chroni_rd_ack, cpu_ack, mem_rd, mem_wr, busy, chroni_data, cpu_rdata, mem_addr, mem_wdata});
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      vectors++;
      if (chroni_rd_ack !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abandoned_access c%0d: ack=%b busy=%b, required 0/0", k, chroni_rd_ack, busy);
      end
    end
    chroni_op(8'h01, 14'h0005, 8'hA5, lat, seen);
    vectors++;
    if (lat !== 3 || seen !== 17'h00205) begin
      miscompares++;
      $display("FAIL post_reset_read: lat %0d addr %h, required 3 00205", lat, seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_cpu_write();
    test_starvation();
    test_wrap_latency();
    test_isolation();
    test_reset_mid_wait();
    vectors++;
    if (sb_chroni.size() + sb_chroni_3.size() + sb_cpu.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0",
               sb_chroni.size() + sb_chroni_3.size() + sb_cpu.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
